// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared defaults and helpers for the serial pattern detector
package seq_det_pkg;

    localparam logic [4:0] DEFAULT_PATTERN = 5'b10101;
    localparam int         DEFAULT_LEN     = 5;

    // A zero length would never match, so it is treated as one; anything wider
    // than the hardware window collapses to the full window.
    function automatic int clamp_len(input int len, input int max_len);
        return (len == 0) ? 1 : (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/seq_det_match.sv
// seq_det_match: masked compare of the newest len bits of {hist, x} against pat
module seq_det_match #(
    parameter  int MAX_LEN = 8,
    localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic [MAX_LEN-1:0] hist_i,
    input  logic               x_i,
    input  logic [MAX_LEN-1:0] pat_i,
    input  logic [LEN_W-1:0]   len_i,
    output logic               match_o
);

    logic [MAX_LEN:0] word;
    logic [MAX_LEN:0] mask;

    // Only the low len bits take part; the mask is built by shifting ones out.
    always_comb begin
        word    = {hist_i, x_i};
        mask    = ~({(MAX_LEN + 1){1'b1}} << len_i);
        match_o = ((word ^ {1'b0, pat_i}) & mask) == '0;
    end

endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable serial pattern detector with Mealy/registered match and saturating count
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               x,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               z,
    output logic               z_q,
    output logic [CNT_W-1:0]   match_count
);

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               raw_match;

    seq_det_match #(.MAX_LEN(MAX_LEN)) u_match (
        .hist_i  (hist_q),
        .x_i     (x),
        .pat_i   (pat_q),
        .len_i   (len_q),
        .match_o (raw_match)
    );

    // Mealy match: a full window of valid history plus the current bit must agree with the pattern.
    assign z = in_valid && !cfg_load && (fill_q >= len_q - LEN_W'(1)) && raw_match;

    assign match_count = cnt_q;

    // Next-state: configuration load wins over data; idle cycles hold everything.
    always_comb begin
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        if (cfg_load) begin
            pat_d  = cfg_pattern;
            len_d  = LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));
            ovl_d  = cfg_overlap;
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
        end else if (in_valid) begin
            hist_d = {hist_q[MAX_LEN-2:0], x};
            fill_d = (z && !ovl_q) ? '0 :
                     (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
            cnt_d  = (z && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
        end
    end

    // State registers with synchronous reset back to the default pattern.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q  <= MAX_LEN'(DEFAULT_PATTERN);
            len_q  <= LEN_W'(DEFAULT_LEN);
            ovl_q  <= 1'b1;
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            z_q    <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            z_q    <= z;
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: scoreboard bench with a bit-queue reference model
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    typedef struct {
        int z;
        int zq;
        int cnt;
        int cnt2;
    } exp_t;

    logic               clk = 0;
    logic               rst;
    logic               in_valid;
    logic               x;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               z, z_q, z2, z_q2;
    logic [7:0]         match_count;
    logic [1:0]         match_count2;

    int checks   = 0;
    int failures = 0;

    exp_t sb[$];

    // reference model state: pattern config plus the raw bits seen since the last clear
    logic [7:0] pat_m;
    int         len_m;
    bit         ovl_m;
    bit         bits_m[$];
    int         cnt_m, cnt2_m;
    int         zq_m;

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
        .clk(clk), .reset(rst), .in_valid(in_valid), .x(x), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .z(z), .z_q(z_q), .match_count(match_count)
    );

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut2 (
        .clk(clk), .reset(rst), .in_valid(in_valid), .x(x), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .z(z2), .z_q(z_q2), .match_count(match_count2)
    );

    always #5 clk = ~clk;

    function automatic bit model_match(input bit xb);
        bit c[$];
        c = bits_m;
        c.push_back(xb);
        if (c.size() < len_m) return 0;
        for (int i = 0; i < len_m; i++)
            if (c[c.size() - 1 - i] != pat_m[i]) return 0;
        return 1;
    endfunction

    task automatic model_reset();
        pat_m  = 8'b00010101;
        len_m  = 5;
        ovl_m  = 1;
        bits_m = {};
        cnt_m  = 0;
        cnt2_m = 0;
        zq_m   = 0;
    endtask

    task automatic cyc(input bit r, input bit v, input bit xb, input bit ld,
                       input logic [7:0] cp, input logic [3:0] cl, input bit co);
        bit zm;
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; in_valid = v; x = xb; cfg_load = ld;
        cfg_pattern = cp; cfg_len = cl; cfg_overlap = co;
        if (r) begin
            model_reset();
            return;
        end
        zm = v && !ld && model_match(xb);
        e.z = int'(zm); e.zq = zq_m; e.cnt = cnt_m; e.cnt2 = cnt2_m;
        sb.push_back(e);
        zq_m = int'(zm);
        if (ld) begin
            pat_m  = cp;
            len_m  = (cl == 0) ? 1 : (int'(cl) > MAX_LEN) ? MAX_LEN : int'(cl);
            ovl_m  = co;
            bits_m = {};
            cnt_m  = 0;
            cnt2_m = 0;
        end else if (v) begin
            bits_m.push_back(xb);
            if (bits_m.size() > MAX_LEN) void'(bits_m.pop_front());
            if (zm) begin
                if (cnt_m < 255) cnt_m++;
                if (cnt2_m < 3) cnt2_m++;
                if (!ovl_m) bits_m = {};
            end
        end
    endtask

    task automatic bitc(input bit xb);
        cyc(0, 1, xb, 0, 8'h00, 4'd0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 1, 0, 8'h00, 4'd0, 0);
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input bit o);
        cyc(0, 0, 0, 1, p, l, o);
    endtask

    task automatic send(input logic [15:0] b, input int n, input int gap);
        logic [15:0] t;
        t = b;
        for (int i = n - 1; i >= 0; i--) begin
            bitc(t[i]);
            idle(gap);
        end
    endtask

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // monitor: compares the DUT outputs against the oldest scoreboard entry mid-cycle
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("z", int'(z), e.z);
            check("z_q", int'(z_q), e.zq);
            check("match_count", int'(match_count), e.cnt);
            check("match_count_cnt2", int'(match_count2), e.cnt2);
            check("z_cnt2", int'(z2), e.z);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; in_valid = 0; x = 0; cfg_load = 0;
        cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0;
        model_reset();
        cyc(1, 0, 0, 0, 8'h00, 4'd0, 0);
        cyc(1, 0, 0, 0, 8'h00, 4'd0, 0);
        // defaults, dense overlapping
        send(16'b1010101, 7, 0);
        idle(2);
        // non-overlapping
        load(8'b10101, 4'd5, 0);
        send(16'b1010101, 7, 0);
        send(16'b0101, 4, 0);
        idle(2);
        // defaults with idle gaps
        cyc(1, 0, 0, 0, 8'h00, 4'd0, 0);
        send(16'b10101, 5, 3);
        // 8-bit pattern, clamped lengths
        load(8'b11010011, 4'd8, 1);
        send(16'b011010011, 9, 0);
        load(8'b11010011, 4'd12, 1);
        send(16'b011010011, 9, 0);
        load(8'b00000001, 4'd0, 1);
        send(16'b1101001110, 10, 0);
        // load in the middle of a partial match
        load(8'b10101, 4'd5, 1);
        send(16'b1010, 4, 0);
        cyc(0, 1, 1, 1, 8'b10101, 4'd5, 1);
        send(16'b0110101, 7, 0);
        // reset in the middle of a partial match
        send(16'b1010, 4, 0);
        cyc(1, 0, 0, 0, 8'h00, 4'd0, 0);
        send(16'b1010101, 7, 0);
        // saturation of both counters
        load(8'b1, 4'd1, 1);
        for (int i = 0; i < 270; i++) bitc(1);
        cyc(0, 1, 0, 0, 8'h00, 4'd0, 0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (r == 0)
                cyc(1, 0, 0, 0, 8'h00, 4'd0, 0);
            else if (r < 5)
                cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 8'($urandom),
                    (r < 3) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4)),
                    1'($urandom_range(0, 1)));
            else
                cyc(0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 0, 8'($urandom),
                    4'($urandom), 1'($urandom_range(0, 1)));
        end
        idle(3);
        @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
